acc_ctrl: RTL and testbench

Memory-mapped sequencer for the matrix accelerator behind the data-RAM wrapper. It decodes a 16-byte register page inside the accelerator address window and issues a single-cycle start pulse to the accelerator. It tracks busy/done/timeout status, counts run cycles, and asserts a buffer lock so the wrapper blocks core access to the operand/result buffers while a run is in flight.

---
 rtl/acc_ctrl_pkg.sv | 34 +++
 rtl/acc_ctrl_regs.sv | 121 ++++++++++++
 rtl/acc_ctrl.sv | 121 ++++++++++++
 tb/tb_acc_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_ctrl_pkg.sv
// ============================================================================
// Module  : acc_ctrl_pkg
// Brief   : Register map, bit indices and FSM state type for acc_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package acc_ctrl_pkg;

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_CYCLES  = 2'd2;
    localparam logic [1:0] OFF_TIMEOUT = 2'd3;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_ABORT_BIT  = 2;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_TIMEOUT_BIT = 2;
    localparam int STAT_ABORTED_BIT = 3;

    localparam logic [31:0] TIMEOUT_DEFAULT_C = 32'd4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } acc_state_e;

endpackage

`default_nettype wire

// File: rtl/acc_ctrl_regs.sv
// ============================================================================
// Module  : acc_ctrl_regs
// Brief   : Register page: decode, byte-lane writes, W1C status, read mux.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_ctrl_regs
    import acc_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 15,
    parameter logic [ADDR_WIDTH-1:0] REG_BASE        = 15'h0400,
    parameter logic [31:0]           TIMEOUT_DEFAULT = TIMEOUT_DEFAULT_C
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic                  busy_i,
    input  logic [31:0]           cycles_i,
    input  logic                  set_done_i,
    input  logic                  set_timeout_i,
    input  logic                  set_aborted_i,
    output logic                  start_req_o,
    output logic                  abort_req_o,
    output logic [31:0]           timeout_val_o,
    output logic [31:0]           rdata_o,
    output logic                  irq_o
);

    logic        hit;
    logic [1:0]  off;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_timeout;
    logic        unused_addr_lsb;

    logic        irq_en_q,  irq_en_d;
    logic        done_q,    done_d;
    logic        tmo_q,     tmo_d;
    logic        abrt_q,    abrt_d;
    logic [31:0] tval_q,    tval_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [31:0] rd_word;

    assign hit             = en_i && (addr_i[ADDR_WIDTH-1:4] == REG_BASE[ADDR_WIDTH-1:4]);
    assign off             = addr_i[3:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    assign wr_ctrl    = hit && we_i && (off == OFF_CTRL) && be_i[0];
    assign wr_status  = hit && we_i && (off == OFF_STATUS) && be_i[0];
    assign wr_timeout = hit && we_i && (off == OFF_TIMEOUT);

    assign start_req_o   = wr_ctrl && wdata_i[CTRL_START_BIT];
    assign abort_req_o   = wr_ctrl && wdata_i[CTRL_ABORT_BIT];
    assign timeout_val_o = tval_q;
    assign rdata_o       = rdata_q;
    assign irq_o         = irq_en_q && (done_q || tmo_q || abrt_q);

    always_comb begin
        rd_word = '0;
        case (off)
            OFF_CTRL:   rd_word[CTRL_IRQ_EN_BIT] = irq_en_q;
            OFF_STATUS: begin
                rd_word[STAT_BUSY_BIT]    = busy_i;
                rd_word[STAT_DONE_BIT]    = done_q;
                rd_word[STAT_TIMEOUT_BIT] = tmo_q;
                rd_word[STAT_ABORTED_BIT] = abrt_q;
            end
            OFF_CYCLES:  rd_word = cycles_i;
            default:     rd_word = tval_q;
        endcase
    end

    always_comb begin
        irq_en_d = irq_en_q;
        tval_d   = tval_q;
        rdata_d  = rdata_q;
        if (wr_ctrl) begin
            irq_en_d = wdata_i[CTRL_IRQ_EN_BIT];
        end
        // A flag being set in the same cycle it is cleared stays set.
        done_d = (done_q && !(wr_status && wdata_i[STAT_DONE_BIT])) || set_done_i;
        tmo_d  = (tmo_q  && !(wr_status && wdata_i[STAT_TIMEOUT_BIT])) || set_timeout_i;
        abrt_d = (abrt_q && !(wr_status && wdata_i[STAT_ABORTED_BIT])) || set_aborted_i;
        if (wr_timeout) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    tval_d[8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
        end
        if (hit && !we_i) begin
            rdata_d = rd_word;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            abrt_q   <= 1'b0;
            tval_q   <= TIMEOUT_DEFAULT;
            rdata_q  <= '0;
        end else begin
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            abrt_q   <= abrt_d;
            tval_q   <= tval_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/acc_ctrl.sv
// ============================================================================
// Module  : acc_ctrl
// Brief   : Accelerator run sequencer: start pulse, run FSM, cycle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 15,
    parameter logic [ADDR_WIDTH-1:0] REG_BASE        = 15'h0400,
    parameter logic [31:0]           TIMEOUT_DEFAULT = TIMEOUT_DEFAULT_C
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    output logic [31:0]           rdata_o,
    output logic                  acc_start_o,
    input  logic                  acc_done_i,
    output logic                  buf_lock_o,
    output logic                  irq_o
);

    acc_state_e  state_q, state_d;
    logic [31:0] cycles_q, cycles_d;
    logic        set_done, set_tmo, set_abrt;
    logic        start_req, abort_req;
    logic [31:0] timeout_val;
    logic        busy;

    assign busy        = (state_q != IDLE);
    assign buf_lock_o  = busy;
    assign acc_start_o = (state_q == START);

    acc_ctrl_regs #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .REG_BASE        (REG_BASE),
        .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT)
    ) u_regs (
        .clk           (clk),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .we_i          (we_i),
        .be_i          (be_i),
        .busy_i        (busy),
        .cycles_i      (cycles_q),
        .set_done_i    (set_done),
        .set_timeout_i (set_tmo),
        .set_aborted_i (set_abrt),
        .start_req_o   (start_req),
        .abort_req_o   (abort_req),
        .timeout_val_o (timeout_val),
        .rdata_o       (rdata_o),
        .irq_o         (irq_o)
    );

    // Exit priority in START/RUN is done > abort > timeout.
    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        set_done = 1'b0;
        set_tmo  = 1'b0;
        set_abrt = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req && abort_req) begin
                    set_abrt = 1'b1;
                end else if (start_req) begin
                    state_d  = START;
                    cycles_d = 32'd1;
                end
            end
            START: begin
                if (acc_done_i) begin
                    state_d  = IDLE;
                    set_done = 1'b1;
                end else if (abort_req) begin
                    state_d  = IDLE;
                    set_abrt = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (acc_done_i) begin
                    state_d  = IDLE;
                    set_done = 1'b1;
                end else if (abort_req) begin
                    state_d  = IDLE;
                    set_abrt = 1'b1;
                end else if ((timeout_val != 32'd0) && (cycles_q >= timeout_val)) begin
                    state_d = IDLE;
                    set_tmo = 1'b1;
                end else if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_acc_ctrl.sv
// ============================================================================
// Module  : tb_acc_ctrl
// Brief   : Directed self-checking bench for acc_ctrl with a run-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_acc_ctrl;

    localparam logic [14:0] A_CTRL   = 15'h0400;
    localparam logic [14:0] A_STATUS = 15'h0404;
    localparam logic [14:0] A_CYCLES = 15'h0408;
    localparam logic [14:0] A_TMO    = 15'h040C;
    localparam logic [14:0] A_OTHER  = 15'h0500;
    localparam logic [10:0] PAGE     = 11'h040;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic [14:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic        acc_done_i = 1'b0;
    logic [31:0] rdata_o;
    logic        acc_start_o;
    logic        buf_lock_o;
    logic        irq_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Run-level model: a run is "active" with an age counted from its start pulse.
    bit          m_active;
    longint      m_age;
    logic [31:0] m_last_cyc, m_tmo, m_rdata;
    bit          m_irq_en, m_done, m_to, m_ab;

    acc_ctrl dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .rdata_o     (rdata_o),
        .acc_start_o (acc_start_o),
        .acc_done_i  (acc_done_i),
        .buf_lock_o  (buf_lock_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] m_cycles();
        if (!m_active) return m_last_cyc;
        if (m_age == 0) return 32'd1;
        return m_age[31:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst_i);
            if (rst_i) begin
                m_active = 0; m_age = 0; m_last_cyc = '0; m_tmo = 32'd4096;
                m_rdata = '0; m_irq_en = 0; m_done = 0; m_to = 0; m_ab = 0;
            end else begin : step
                bit          hit, wctrl, st_w, ab_w, ev_d, ev_a, ev_t;
                logic [1:0]  off;
                logic [31:0] cyc;
                hit   = en_i && (addr_i[14:4] == PAGE);
                off   = addr_i[3:2];
                if (hit && !we_i) begin
                    case (off)
                        2'd0:    m_rdata = m_irq_en ? 32'h2 : 32'h0;
                        2'd1:    m_rdata = {28'b0, m_ab, m_to, m_done, m_active};
                        2'd2:    m_rdata = m_cycles();
                        default: m_rdata = m_tmo;
                    endcase
                end
                wctrl = hit && we_i && (off == 2'd0) && be_i[0];
                st_w  = wctrl && wdata_i[0];
                ab_w  = wctrl && wdata_i[2];
                ev_d = 0; ev_a = 0; ev_t = 0;
                if (m_active) begin
                    cyc = m_cycles();
                    if (acc_done_i)                                     ev_d = 1;
                    else if (ab_w)                                      ev_a = 1;
                    else if (m_age > 0 && m_tmo != 0 && cyc >= m_tmo)   ev_t = 1;
                    if (ev_d || ev_a || ev_t) begin
                        m_active   = 0;
                        m_last_cyc = cyc;
                    end else begin
                        m_age++;
                    end
                end else if (st_w) begin
                    if (ab_w) ev_a = 1;
                    else begin m_active = 1; m_age = 0; end
                end
                if (hit && we_i && off == 2'd1 && be_i[0]) begin
                    if (wdata_i[1]) m_done = 0;
                    if (wdata_i[2]) m_to   = 0;
                    if (wdata_i[3]) m_ab   = 0;
                end
                m_done = m_done || ev_d;
                m_to   = m_to   || ev_t;
                m_ab   = m_ab   || ev_a;
                if (wctrl) m_irq_en = wdata_i[1];
                if (hit && we_i && off == 2'd3) begin
                    for (int b = 0; b < 4; b++)
                        if (be_i[b]) m_tmo[8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst_i) begin
                chk("acc_start_o", {31'b0, acc_start_o}, {31'b0, m_active && m_age == 0});
                chk("buf_lock_o",  {31'b0, buf_lock_o},  {31'b0, m_active});
                chk("irq_o",       {31'b0, irq_o},       {31'b0, m_irq_en && (m_done || m_to || m_ab)});
                chk("rdata_o",     rdata_o,              m_rdata);
            end
        end
    end

    task automatic wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be, input logic done);
        en_i = 1; we_i = 1; addr_i = a; wdata_i = d; be_i = be; acc_done_i = done;
        @(negedge clk);
        en_i = 0; we_i = 0; be_i = '0; wdata_i = '0; acc_done_i = 0;
    endtask

    task automatic rd(input logic [14:0] a, output logic [31:0] d);
        en_i = 1; we_i = 0; addr_i = a;
        @(negedge clk);
        en_i = 0;
        d = rdata_o;
    endtask

    task automatic pulse_done();
        acc_done_i = 1;
        @(negedge clk);
        acc_done_i = 0;
    endtask

    initial begin
        logic [31:0] v;
        int          extra;
        bit          lock_all;

        #1 rst_i = 1;
        @(negedge clk); @(negedge clk);
        #1 rst_i = 0;
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_start", {31'b0, acc_start_o}, 32'h0);
        chk("reset_lock",  {31'b0, buf_lock_o}, 32'h0);
        chk("reset_irq",   {31'b0, irq_o}, 32'h0);
        chk_en = 1;
        rd(A_TMO, v);     chk("reset_timeout", v, 32'd4096);

        // Nominal run: done 20 cycles after the start pulse
        wr(A_CTRL, 32'h3, 4'hF, 1'b0);
        chk("nom_start_pulse", {31'b0, acc_start_o}, 32'h1);
        extra = 0; lock_all = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (acc_start_o) extra++;
            lock_all = lock_all && buf_lock_o;
        end
        pulse_done();
        chk("nom_extra_pulses", extra, 32'd0);
        chk("nom_lock_held", {31'b0, lock_all}, 32'h1);
        chk("nom_lock_released", {31'b0, buf_lock_o}, 32'h0);
        rd(A_STATUS, v);  chk("nom_status", v, 32'h2);
        rd(A_CYCLES, v);  chk("nom_cycles", v, 32'd20);
        chk("nom_irq", {31'b0, irq_o}, 32'h1);
        wr(A_STATUS, 32'h2, 4'hF, 1'b0);
        chk("nom_irq_cleared", {31'b0, irq_o}, 32'h0);

        // Timeout
        wr(A_TMO, 32'd8, 4'hF, 1'b0);
        wr(A_CTRL, 32'h1, 4'hF, 1'b0);
        for (int k = 0; k < 40 && buf_lock_o; k++) @(negedge clk);
        chk("tmo_run_ended", {31'b0, buf_lock_o}, 32'h0);
        rd(A_STATUS, v);  chk("tmo_status", v, 32'h4);
        rd(A_CYCLES, v);  chk("tmo_cycles", v, 32'd8);
        wr(A_STATUS, 32'hE, 4'hF, 1'b0);

        // Abort in the third RUN cycle, then a stray done in IDLE
        wr(A_CTRL, 32'h3, 4'hF, 1'b0);
        repeat (3) @(negedge clk);
        wr(A_CTRL, 32'h6, 4'hF, 1'b0);
        chk("abort_lock", {31'b0, buf_lock_o}, 32'h0);
        pulse_done();
        rd(A_STATUS, v);  chk("abort_status", v, 32'h8);
        chk("abort_irq", {31'b0, irq_o}, 32'h1);
        wr(A_STATUS, 32'hE, 4'hF, 1'b0);

        // START while busy, then done and abort together
        wr(A_CTRL, 32'h3, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        wr(A_CTRL, 32'h3, 4'hF, 1'b0);
        extra = (acc_start_o) ? 1 : 0;
        @(negedge clk);
        if (acc_start_o) extra++;
        chk("busy_restart_pulses", extra, 32'd0);
        wr(A_CTRL, 32'h6, 4'hF, 1'b1);
        rd(A_STATUS, v);  chk("done_vs_abort", v, 32'h2);

        // DONE W1C coinciding with a new done event
        wr(A_CTRL, 32'h3, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        wr(A_STATUS, 32'h2, 4'hF, 1'b1);
        rd(A_STATUS, v);  chk("set_beats_w1c", v, 32'h2);

        // START+ABORT in IDLE
        wr(A_STATUS, 32'hE, 4'hF, 1'b0);
        wr(A_CTRL, 32'h5, 4'hF, 1'b0);
        chk("start_abort_no_run", {31'b0, buf_lock_o}, 32'h0);
        rd(A_STATUS, v);  chk("start_abort_status", v, 32'h8);
        wr(A_STATUS, 32'hE, 4'hF, 1'b0);

        // Byte enables
        wr(A_CTRL, 32'h1, 4'b0010, 1'b0);
        chk("be_no_start", {31'b0, buf_lock_o}, 32'h0);
        wr(A_TMO, 32'hAABBCCDD, 4'b0001, 1'b0);
        rd(A_TMO, v);     chk("be_timeout_byte0", v, 32'h0000_00DD);
        rd(A_OTHER, v);   chk("offpage_read_holds", v, 32'h0000_00DD);

        // Asynchronous reset in the middle of a run
        wr(A_CTRL, 32'h3, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_i = 1;
        #1;
        chk("async_rst_lock",  {31'b0, buf_lock_o}, 32'h0);
        chk("async_rst_start", {31'b0, acc_start_o}, 32'h0);
        chk("async_rst_rdata", rdata_o, 32'h0);
        chk("async_rst_irq",   {31'b0, irq_o}, 32'h0);
        @(negedge clk);
        #1 rst_i = 0;
        rd(A_TMO, v);     chk("post_rst_timeout", v, 32'd4096);
        rd(A_CYCLES, v);  chk("post_rst_cycles", v, 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
